// File: rtl/aes_sbox_col_feeder.sv
// Valid/ready front end for the four masked S-box lanes of the 32-bit AES core.
// Tracks in-flight columns and buffers lane results in a credit-checked FIFO.
module aes_sbox_col_feeder #(
  parameter int d          = 2,
  parameter int OUT_LAT    = 4,
  parameter int FIFO_DEPTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*d-1:0] in_data,
  input  logic            rnd_fresh,
  output logic            rnd_used,
  output logic [32*d-1:0] sbox_in,
  input  logic [32*d-1:0] sbox_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*d-1:0] out_data
);

  localparam int W  = 32 * d;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(OUT_LAT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [OUT_LAT-1:0] r_vsr;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [W-1:0]       r_mem [FIFO_DEPTH];

  logic [IW-1:0] w_inflight;
  logic          w_credit;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < OUT_LAT; i++)
      w_inflight = w_inflight + IW'(r_vsr[i]);
  end

  // Reserve a FIFO slot for every word still inside the lanes.
  assign w_credit =
    (32'(r_cnt) + 32'(w_inflight)) < 32'(FIFO_DEPTH);

  assign in_ready  = !rst && rnd_fresh && w_credit;
  assign w_issue   = in_valid && in_ready;
  assign rnd_used  = w_issue;
  assign sbox_in   = in_data;

  assign w_push    = r_vsr[OUT_LAT-1];
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsr <= '0;
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      r_vsr[0] <= w_issue;
      for (int i = 1; i < OUT_LAT; i++)
        r_vsr[i] <= r_vsr[i-1];
      if (w_push)
        r_wr <= nxt(r_wr);
      if (w_pop)
        r_rd <= nxt(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= sbox_out;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(w_push && !w_pop && r_cnt == CW'(FIFO_DEPTH))
  );

endmodule
